// File: rtl/rr_stream_merge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_stream_merge_pkg
// Brief    : Shared sizing helpers, defaults and data type for rr_stream_merge.
// Revision : 1.0 - initial release
// ============================================================================
package rr_stream_merge_pkg;

    localparam int DEFAULT_N     = 5;
    localparam int DEFAULT_WIDTH = 32;

    typedef logic [DEFAULT_WIDTH-1:0] data_t;

    // A single channel still needs a 1-bit select so ports never collapse to zero width.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/commonlib_muxn.sv
`default_nettype none
// ============================================================================
// Module   : commonlib_muxn
// Brief    : Parameterised N:1 data mux (commonlib_muxn__N{N}__width{WIDTH} family).
// Revision : 1.0 - initial release
// ============================================================================
module commonlib_muxn
    import rr_stream_merge_pkg::*;
#(
    parameter  int N     = DEFAULT_N,
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int SEL_W = sel_w(N)
) (
    input  logic [WIDTH-1:0] I [N-1:0],
    input  logic [SEL_W-1:0] S,
    output logic [WIDTH-1:0] O
);

    always_comb begin
        O = '0;
        for (int k = 0; k < N; k++) begin
            if (S == SEL_W'(k)) begin
                O = I[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_n
// Brief    : Combinational round-robin arbiter, search starts at ptr and wraps.
//            RR_STREAM_MERGE_LOCK_EN adds a lock that pins the grant to lock_idx.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_n
    import rr_stream_merge_pkg::*;
#(
    parameter  int N     = DEFAULT_N,
    localparam int SEL_W = sel_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
`ifdef RR_STREAM_MERGE_LOCK_EN
    input  logic             lock,
    input  logic [SEL_W-1:0] lock_idx,
`endif
    output logic [N-1:0]     gnt_onehot,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any_gnt
);

    always_comb begin
        int w_idx;
        w_idx      = 0;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any_gnt    = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!any_gnt && req[SEL_W'(w_idx)]) begin
                any_gnt                    = 1'b1;
                gnt_idx                    = SEL_W'(w_idx);
                gnt_onehot[SEL_W'(w_idx)]  = 1'b1;
            end
        end
`ifdef RR_STREAM_MERGE_LOCK_EN
        // While a packet is in flight only its owner may be granted, even if it goes idle.
        if (lock) begin
            gnt_onehot = '0;
            gnt_idx    = lock_idx;
            any_gnt    = req[lock_idx];
            if (req[lock_idx]) begin
                gnt_onehot[lock_idx] = 1'b1;
            end
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/rr_stream_merge.sv
`default_nettype none
// ============================================================================
// Module   : rr_stream_merge
// Brief    : Round-robin N-to-1 valid/ready merger with a registered output stage.
//            Optional packet lock: define RR_STREAM_MERGE_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rr_stream_merge
    import rr_stream_merge_pkg::*;
#(
    parameter  int N     = DEFAULT_N,
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int SEL_W = sel_w(N)
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic [WIDTH-1:0] I [N-1:0],
    input  logic [N-1:0]     I_valid,
`ifdef RR_STREAM_MERGE_LOCK_EN
    input  logic [N-1:0]     I_last,
    output logic             O_last,
`endif
    output logic [N-1:0]     I_ready,
    output logic [WIDTH-1:0] O,
    output logic             O_valid,
    input  logic             O_ready,
    output logic [SEL_W-1:0] S
);

    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_s;
    logic [WIDTH-1:0] r_o;
    logic             r_o_valid;

    logic             w_load;
    logic             w_xfer;
    logic [N-1:0]     w_gnt_onehot;
    logic [SEL_W-1:0] w_gnt_idx;
    logic             w_any_gnt;
    logic [WIDTH-1:0] w_mux_o;
    logic [SEL_W-1:0] w_ptr_next;

`ifdef RR_STREAM_MERGE_LOCK_EN
    logic             r_lock;
    logic             r_o_last;
`endif

    rr_arbiter_n #(
        .N          (N)
    ) u_arbiter (
        .req        (I_valid),
        .ptr        (r_ptr),
`ifdef RR_STREAM_MERGE_LOCK_EN
        .lock       (r_lock),
        .lock_idx   (r_s),
`endif
        .gnt_onehot (w_gnt_onehot),
        .gnt_idx    (w_gnt_idx),
        .any_gnt    (w_any_gnt)
    );

    commonlib_muxn #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_commonlib_muxn (
        .I     (I),
        .S     (w_gnt_idx),
        .O     (w_mux_o)
    );

    // Reset gates ready directly so sources see no acceptance while held in reset.
    assign w_load     = (~r_o_valid | O_ready) & ASYNCRESETN;
    assign w_xfer     = w_any_gnt & w_load;
    assign I_ready    = w_gnt_onehot & {N{w_load}};
    assign w_ptr_next = (w_gnt_idx == SEL_W'(N - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_ptr     <= '0;
            r_s       <= '0;
            r_o       <= '0;
            r_o_valid <= 1'b0;
`ifdef RR_STREAM_MERGE_LOCK_EN
            r_lock    <= 1'b0;
            r_o_last  <= 1'b0;
`endif
        end else if (w_xfer) begin
            r_o       <= w_mux_o;
            r_s       <= w_gnt_idx;
            r_o_valid <= 1'b1;
`ifdef RR_STREAM_MERGE_LOCK_EN
            r_o_last  <= I_last[w_gnt_idx];
            r_lock    <= ~I_last[w_gnt_idx];
            if (I_last[w_gnt_idx]) begin
                r_ptr <= w_ptr_next;
            end
`else
            r_ptr     <= w_ptr_next;
`endif
        end else if (r_o_valid && O_ready) begin
            r_o_valid <= 1'b0;
        end
    end

    assign O       = r_o;
    assign O_valid = r_o_valid;
    assign S       = r_s;
`ifdef RR_STREAM_MERGE_LOCK_EN
    assign O_last  = r_o_last;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_stream_merge.sv
`default_nettype none
// Testbench for rr_stream_merge: directed stimulus, per-cycle reference model compare
// and literal expectations for the key sequences.
module tb_rr_stream_merge;
    import rr_stream_merge_pkg::*;

    localparam int N = 5;
    localparam int W = 32;

    logic         CLK   = 1'b0;
    logic         rst_n = 1'b0;
    data_t        din [N-1:0];
    logic [N-1:0] vin;
    logic [N-1:0] rdy;
    logic [W-1:0] dout;
    logic         ovalid;
    logic         oready;
    logic [2:0]   sel;
    logic [N-1:0] lin;
`ifdef RR_STREAM_MERGE_LOCK_EN
    logic         olast;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 CLK = ~CLK;

    rr_stream_merge #(.N(N), .WIDTH(W)) dut (
        .CLK         (CLK),
        .ASYNCRESETN (rst_n),
        .I           (din),
        .I_valid     (vin),
`ifdef RR_STREAM_MERGE_LOCK_EN
        .I_last      (lin),
        .O_last      (olast),
`endif
        .I_ready     (rdy),
        .O           (dout),
        .O_valid     (ovalid),
        .O_ready     (oready),
        .S           (sel)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    // Reference model: abstract pointer, held beat and lock owner.
    int         m_ptr   = 0;
    int         m_s     = 0;
    logic       m_ov    = 1'b0;
    logic [W-1:0] m_o   = '0;
    bit         m_lock  = 1'b0;
    bit         m_olast = 1'b0;

    function automatic int winner(input logic [N-1:0] v, input int p, input bit lk, input int ls);
        if (lk) return v[ls] ? ls : -1;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge CLK or negedge rst_n) begin
        automatic int w;
        automatic bit ld;
        if (!rst_n) begin
            m_ptr   <= 0;
            m_s     <= 0;
            m_ov    <= 1'b0;
            m_o     <= '0;
            m_lock  <= 1'b0;
            m_olast <= 1'b0;
        end else begin
            ld = !m_ov || oready;
            w  = winner(vin, m_ptr, m_lock, m_s);
            if (ld && w >= 0) begin
                m_o  <= din[w];
                m_s  <= w;
                m_ov <= 1'b1;
`ifdef RR_STREAM_MERGE_LOCK_EN
                m_olast <= lin[w];
                m_lock  <= !lin[w];
                if (lin[w]) m_ptr <= (w + 1) % N;
`else
                m_ptr <= (w + 1) % N;
`endif
            end else if (m_ov && oready) begin
                m_ov <= 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        automatic int w;
        automatic logic [N-1:0] er;
        if (chk_on) begin
            w  = winner(vin, m_ptr, m_lock, m_s);
            er = '0;
            if (rst_n && (!m_ov || oready) && w >= 0) er = N'(1 << w);
            chk("cmp_i_ready", 64'(rdy), 64'(er));
            chk("cmp_o_valid", 64'(ovalid), 64'(m_ov));
            chk("cmp_o", 64'(dout), 64'(m_o));
            chk("cmp_s", 64'(sel), 64'(m_s));
`ifdef RR_STREAM_MERGE_LOCK_EN
            chk("cmp_o_last", 64'(olast), 64'(m_olast));
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        automatic int ord7 [7] = '{0, 1, 2, 3, 4, 0, 1};
        automatic int ord3 [3] = '{2, 4, 2};

        vin    = '0;
        oready = 1'b1;
        lin    = '1;
        for (int k = 0; k < N; k++) din[k] = 32'hA0 + k;

        repeat (3) @(negedge CLK);
        #1;
        chk_on = 1'b1;
        chk("rst_o_valid", 64'(ovalid), 64'd0);
        chk("rst_s", 64'(sel), 64'd0);
        chk("rst_o", 64'(dout), 64'd0);
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_ready", 64'(rdy), 64'd0);
            chk("idle_o_valid", 64'(ovalid), 64'd0);
            chk("idle_s", 64'(sel), 64'd0);
        end

        // All channels requesting: strict rotation with wrap
        vin = 5'b11111;
        #1;
        chk("rr_first_ready", 64'(rdy), 64'b00001);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("rr_o", 64'(dout), 64'(32'hA0 + ord7[i]));
            chk("rr_s", 64'(sel), 64'(ord7[i]));
            chk("rr_o_valid", 64'(ovalid), 64'd1);
            if (i == 6) vin = '0;
        end
        tick();
        chk("rr_drain", 64'(ovalid), 64'd0);
        chk("rr_hold_o", 64'(dout), 64'hA1);

        // Sparse requests
        vin = 5'b10100;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sparse_o", 64'(dout), 64'(32'hA0 + ord3[i]));
            chk("sparse_s", 64'(sel), 64'(ord3[i]));
            if (i == 2) begin
                vin    = '0;
                oready = 1'b0;
            end
        end

        // Backpressure, then simultaneous drain and fill
        vin = 5'b00011;
        #1;
        chk("bp_ready", 64'(rdy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_o", 64'(dout), 64'hA2);
            chk("bp_s", 64'(sel), 64'd2);
            chk("bp_o_valid", 64'(ovalid), 64'd1);
            chk("bp_ready", 64'(rdy), 64'd0);
        end
        oready = 1'b1;
        #1;
        chk("fill_ready", 64'(rdy), 64'b00001);
        tick();
        chk("fill_o", 64'(dout), 64'hA0);
        chk("fill_s", 64'(sel), 64'd0);
        chk("fill_o_valid", 64'(ovalid), 64'd1);
        vin = '0;

        // Asynchronous reset in mid-cycle while holding a beat from ch3
        vin = 5'b01000;
        tick();
        chk("pre_rst_s", 64'(sel), 64'd3);
        vin    = '0;
        oready = 1'b0;
        #2;
        rst_n = 1'b0;
        vin   = 5'b11111;
        #1;
        chk("async_rst_o_valid", 64'(ovalid), 64'd0);
        chk("async_rst_s", 64'(sel), 64'd0);
        chk("async_rst_o", 64'(dout), 64'd0);
        chk("async_rst_ready", 64'(rdy), 64'd0);
        tick();
        tick();
        rst_n  = 1'b1;
        oready = 1'b1;
        #1;
        chk("post_rst_ready", 64'(rdy), 64'b00001);
        tick();
        chk("post_rst_o", 64'(dout), 64'hA0);
        chk("post_rst_s", 64'(sel), 64'd0);
        vin = '0;

`ifdef RR_STREAM_MERGE_LOCK_EN
        // ch1 sends a 3-beat packet; lock must survive a valid drop
        vin    = 5'b00111;
        din[1] = 32'hB0;
        lin    = 5'b11101;
        #1;
        chk("lock_first_ready", 64'(rdy), 64'b00010);
        tick();
        chk("lock_o0", 64'(dout), 64'hB0);
        chk("lock_last0", 64'(olast), 64'd0);
        vin = 5'b00101;
        #1;
        chk("lock_gap_ready", 64'(rdy), 64'd0);
        tick();
        chk("lock_gap_o_valid", 64'(ovalid), 64'd0);
        vin    = 5'b00111;
        din[1] = 32'hB1;
        tick();
        chk("lock_o1", 64'(dout), 64'hB1);
        chk("lock_last1", 64'(olast), 64'd0);
        din[1] = 32'hB2;
        lin    = 5'b11111;
        tick();
        chk("lock_o2", 64'(dout), 64'hB2);
        chk("lock_last2", 64'(olast), 64'd1);
        tick();
        chk("lock_after_s", 64'(sel), 64'd2);
        chk("lock_after_o", 64'(dout), 64'hA2);
        tick();
        chk("lock_next_s", 64'(sel), 64'd0);
        chk("lock_next_o", 64'(dout), 64'hA0);
        vin = '0;
`endif

        tick();
        tick();
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
